// File: rtl/sprite_loader.sv
// sprite_loader: turns a byte stream (MAGIC, sel, 48 palette bytes, PIX_COUNT/2 pixel bytes)
// into palette-entry writes and pixel-RAM write strobes for one sprite slot.
// Optional trailing checksum byte: define SPRITE_LOADER_CKSUM_EN.
module sprite_loader #(
    parameter int unsigned PIX_COUNT   = 3600,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned NUM_SPRITES = 9,
    parameter logic [7:0]  MAGIC       = 8'hA5
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        pix_data,
    output logic [3:0]        spr_sel,
    output logic              pal_we,
    output logic [3:0]        pal_idx,
    output logic [23:0]       pal_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(PIX_COUNT - 2);
    localparam logic [7:0]        SEL_LIMIT = 8'(NUM_SPRITES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SEL  = 3'd1,
        PAL  = 3'd2,
        PIX  = 3'd3,
        CK   = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic                in_ready_q, in_ready_d;
    logic                pix_we_q, pix_we_d;
    logic [ADDR_W-1:0]   pix_addr_q, pix_addr_d;
    logic [3:0]          pix_data_q, pix_data_d;
    logic [3:0]          spr_sel_q, spr_sel_d;
    logic                pal_we_q, pal_we_d;
    logic [3:0]          pal_idx_q, pal_idx_d;
    logic [23:0]         pal_data_q, pal_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                done_pend_q, done_pend_d;
    logic                phase_q, phase_d;   // 1 = low nibble still to be written
    logic [3:0]          lo_q, lo_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;     // address of the next even pixel
    logic [1:0]          rgb_q, rgb_d;
    logic [3:0]          ent_q, ent_d;
    logic [7:0]          r_q, r_d;
    logic [7:0]          g_q, g_d;
`ifdef SPRITE_LOADER_CKSUM_EN
    logic [7:0]          cks_q, cks_d;
`endif
    logic                xfer;

    assign xfer = in_valid && in_ready_q;

    // Next-state and registered-output computation
    always_comb begin
        state_d     = state_q;
        pix_we_d    = 1'b0;
        pix_addr_d  = pix_addr_q;
        pix_data_d  = pix_data_q;
        spr_sel_d   = spr_sel_q;
        pal_we_d    = 1'b0;
        pal_idx_d   = pal_idx_q;
        pal_data_d  = pal_data_q;
        done_d      = done_pend_q;
        err_d       = 1'b0;
        done_pend_d = 1'b0;
        phase_d     = phase_q;
        lo_d        = lo_q;
        addr_d      = addr_q;
        rgb_d       = rgb_q;
        ent_d       = ent_q;
        r_d         = r_q;
        g_d         = g_q;
`ifdef SPRITE_LOADER_CKSUM_EN
        cks_d       = cks_q;
`endif
        if (abort) begin
            state_d = IDLE;
            phase_d = 1'b0;
            err_d   = busy_q;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer && in_data == MAGIC) begin
                        state_d = SEL;
`ifdef SPRITE_LOADER_CKSUM_EN
                        cks_d = 8'd0;
`endif
                    end
                end
                SEL: begin
                    if (xfer) begin
                        if (in_data < SEL_LIMIT) begin
                            state_d   = PAL;
                            spr_sel_d = in_data[3:0];
                            rgb_d     = 2'd0;
                            ent_d     = 4'd0;
`ifdef SPRITE_LOADER_CKSUM_EN
                            cks_d = in_data;
`endif
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end
                PAL: begin
                    if (xfer) begin
`ifdef SPRITE_LOADER_CKSUM_EN
                        cks_d = cks_q ^ in_data;
`endif
                        case (rgb_q)
                            2'd0: begin
                                r_d   = in_data;
                                rgb_d = 2'd1;
                            end
                            2'd1: begin
                                g_d   = in_data;
                                rgb_d = 2'd2;
                            end
                            default: begin
                                rgb_d      = 2'd0;
                                pal_we_d   = 1'b1;
                                pal_idx_d  = ent_q;
                                pal_data_d = {r_q, g_q, in_data};
                                ent_d      = ent_q + 4'd1;
                                if (ent_q == 4'd15) begin
                                    state_d = PIX;
                                    addr_d  = '0;
                                    phase_d = 1'b0;
                                end
                            end
                        endcase
                    end
                end
                PIX: begin
                    if (!phase_q) begin
                        if (xfer) begin
                            pix_we_d   = 1'b1;
                            pix_addr_d = addr_q;
                            pix_data_d = in_data[7:4];
                            lo_d       = in_data[3:0];
                            phase_d    = 1'b1;
`ifdef SPRITE_LOADER_CKSUM_EN
                            cks_d = cks_q ^ in_data;
`endif
                        end
                    end else begin
                        pix_we_d   = 1'b1;
                        pix_addr_d = addr_q + ADDR_W'(1);
                        pix_data_d = lo_q;
                        phase_d    = 1'b0;
                        addr_d     = addr_q + ADDR_W'(2);
                        if (addr_q == LAST_PAIR) begin
`ifdef SPRITE_LOADER_CKSUM_EN
                            state_d = CK;
`else
                            state_d     = IDLE;
                            done_pend_d = 1'b1;
`endif
                        end
                    end
                end
`ifdef SPRITE_LOADER_CKSUM_EN
                CK: begin
                    if (xfer) begin
                        state_d = IDLE;
                        if (in_data == cks_q) begin
                            done_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
        in_ready_d = !(state_d == PIX && phase_d);
        busy_d     = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            pix_we_q    <= 1'b0;
            pix_addr_q  <= '0;
            pix_data_q  <= 4'd0;
            spr_sel_q   <= 4'd0;
            pal_we_q    <= 1'b0;
            pal_idx_q   <= 4'd0;
            pal_data_q  <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            done_pend_q <= 1'b0;
            phase_q     <= 1'b0;
            lo_q        <= 4'd0;
            addr_q      <= '0;
            rgb_q       <= 2'd0;
            ent_q       <= 4'd0;
            r_q         <= 8'd0;
            g_q         <= 8'd0;
`ifdef SPRITE_LOADER_CKSUM_EN
            cks_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            pix_we_q    <= pix_we_d;
            pix_addr_q  <= pix_addr_d;
            pix_data_q  <= pix_data_d;
            spr_sel_q   <= spr_sel_d;
            pal_we_q    <= pal_we_d;
            pal_idx_q   <= pal_idx_d;
            pal_data_q  <= pal_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            done_pend_q <= done_pend_d;
            phase_q     <= phase_d;
            lo_q        <= lo_d;
            addr_q      <= addr_d;
            rgb_q       <= rgb_d;
            ent_q       <= ent_d;
            r_q         <= r_d;
            g_q         <= g_d;
`ifdef SPRITE_LOADER_CKSUM_EN
            cks_q       <= cks_d;
`endif
        end
    end

    assign in_ready = in_ready_q;
    assign pix_we   = pix_we_q;
    assign pix_addr = pix_addr_q;
    assign pix_data = pix_data_q;
    assign spr_sel  = spr_sel_q;
    assign pal_we   = pal_we_q;
    assign pal_idx  = pal_idx_q;
    assign pal_data = pal_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule
